// File: rtl/fuec_48_32_pkg.sv
// Shared constants, event classes, IRQ states and the flag-priority decode
// for the (48,32) FUEC decode sink.
package fuec_48_32_pkg;

    localparam int unsigned N        = 48;
    localparam int unsigned K        = 32;
    localparam int unsigned R        = 16;
    localparam int unsigned DATA_MSB = 47;
    localparam int unsigned DATA_LSB = 16;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_CORR,
        EV_UNC
    } ev_class_e;

    typedef enum logic {
        IRQ_IDLE,
        IRQ_PENDING
    } irq_state_e;

    // uncorrectable > corrected > no_error; a valid word with no flag is not trusted
    function automatic ev_class_e decode_class(
        input logic valid,
        input logic no_error,
        input logic corrected,
        input logic uncorrectable
    );
        ev_class_e cls;
        cls = EV_NONE;
        if (!valid) begin
            cls = EV_NONE;
        end else if (uncorrectable) begin
            cls = EV_UNC;
        end else if (corrected) begin
            cls = EV_CORR;
        end else if (!no_error) begin
            cls = EV_UNC;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fuec_scrub_fifo.sv
// Show-ahead FIFO for scrub write-back requests; DEPTH must be a power of two.
// A push while full is accepted only when a pop happens in the same cycle.
module fuec_scrub_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty_c   = (cnt_q == '0);
    assign full_c    = (cnt_q == CNT_W'(DEPTH));
    assign do_pop_c  = pop && !empty_c;
    assign do_push_c = push && (!full_c || do_pop_c);
    assign rdata_c   = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push_c) begin
            wr_d = wr_q + PTR_W'(1);
        end
        if (do_pop_c) begin
            rd_d = rd_q + PTR_W'(1);
        end
        if (do_push_c && !do_pop_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!do_push_c && do_pop_c) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is not reset; only entries below the count are ever presented as valid.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_q] <= wdata;
        end
    end

endmodule

// File: rtl/fuec_decode_sink_48_32.sv
// Consumes fuec_decoder_48_32 results: payload extraction, event counters, last
// error context, sticky IRQ, and (with FUEC_SCRUB_EN) a scrub write-back FIFO.
module fuec_decode_sink_48_32
    import fuec_48_32_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned IRQ_ON_CORR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [R-1:0]      s,
    input  logic [N-1:0]      r_fix,
    input  logic [N-1:0]      pos_error,
    input  logic              no_error,
    input  logic              corrected,
    input  logic              uncorrectable,
    output logic [K-1:0]      data_out,
    output logic              data_valid,
    output logic              data_err,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_unc,
    input  logic              cnt_clr,
    output logic [R-1:0]      last_syndrome,
    output logic [ADDR_W-1:0] last_addr,
    output logic              irq,
    input  logic              irq_clr,
    output logic              scrub_req,
    output logic [ADDR_W-1:0] scrub_addr,
    output logic [N-1:0]      scrub_data,
    input  logic              scrub_ack,
    output logic [CNT_W-1:0]  scrub_drop
);

    ev_class_e         ev_c;
    logic              trig_c;
    irq_state_e        state_q, state_d;
    logic [K-1:0]      data_q, data_d;
    logic              dv_q, dv_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
    logic [CNT_W-1:0]  cnt_unc_q, cnt_unc_d;
    logic [R-1:0]      syn_q, syn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              irq_q, irq_d;
    logic              unused_pos_c;

    assign ev_c         = decode_class(in_valid, no_error, corrected, uncorrectable);
    assign trig_c       = (ev_c == EV_UNC) || ((IRQ_ON_CORR != 0) && (ev_c == EV_CORR));
    assign unused_pos_c = ^pos_error;

    // IRQ FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IRQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath next values; a new trigger beats irq_clr
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        dv_d       = in_valid;
        err_d      = (ev_c == EV_UNC);
        cnt_corr_d = cnt_corr_q;
        cnt_unc_d  = cnt_unc_q;
        syn_d      = syn_q;
        addr_d     = addr_q;

        case (state_q)
            IRQ_IDLE:    if (trig_c) state_d = IRQ_PENDING;
            IRQ_PENDING: if (irq_clr && !trig_c) state_d = IRQ_IDLE;
            default:     state_d = IRQ_IDLE;
        endcase
        irq_d = (state_d == IRQ_PENDING);

        if (in_valid) begin
            data_d = r_fix[DATA_MSB:DATA_LSB];
        end

        if (cnt_clr) begin
            cnt_corr_d = CNT_W'(ev_c == EV_CORR);
            cnt_unc_d  = CNT_W'(ev_c == EV_UNC);
        end else begin
            if ((ev_c == EV_CORR) && (cnt_corr_q != '1)) cnt_corr_d = cnt_corr_q + CNT_W'(1);
            if ((ev_c == EV_UNC) && (cnt_unc_q != '1))   cnt_unc_d  = cnt_unc_q + CNT_W'(1);
        end

        if ((ev_c == EV_CORR) || (ev_c == EV_UNC)) begin
            syn_d  = s;
            addr_d = in_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            dv_q       <= 1'b0;
            err_q      <= 1'b0;
            cnt_corr_q <= '0;
            cnt_unc_q  <= '0;
            syn_q      <= '0;
            addr_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_q     <= data_d;
            dv_q       <= dv_d;
            err_q      <= err_d;
            cnt_corr_q <= cnt_corr_d;
            cnt_unc_q  <= cnt_unc_d;
            syn_q      <= syn_d;
            addr_q     <= addr_d;
            irq_q      <= irq_d;
        end
    end

    assign data_out      = data_q;
    assign data_valid    = dv_q;
    assign data_err      = err_q;
    assign cnt_corr      = cnt_corr_q;
    assign cnt_unc       = cnt_unc_q;
    assign last_syndrome = syn_q;
    assign last_addr     = addr_q;
    assign irq           = irq_q;

`ifdef FUEC_SCRUB_EN
    localparam int unsigned ENTRY_W = ADDR_W + N;

    logic               push_c;
    logic               pop_c;
    logic               full_c;
    logic               empty_c;
    logic [ENTRY_W-1:0] head_c;
    logic [CNT_W-1:0]   drop_q, drop_d;

    assign push_c = (ev_c == EV_CORR);
    assign pop_c  = scrub_ack && !empty_c;

    fuec_scrub_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_c),
        .pop     (pop_c),
        .wdata   ({in_addr, r_fix}),
        .rdata_c (head_c),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    // Drops only when full with no simultaneous pop to make room
    always_comb begin
        drop_d = drop_q;
        if (push_c && full_c && !pop_c && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign scrub_req  = !empty_c;
    assign scrub_addr = head_c[ENTRY_W-1:N];
    assign scrub_data = head_c[N-1:0];
    assign scrub_drop = drop_q;
`else
    logic unused_scrub_c;

    assign unused_scrub_c = ^{scrub_ack, r_fix[R-1:0]};
    assign scrub_req      = 1'b0;
    assign scrub_addr     = '0;
    assign scrub_data     = '0;
    assign scrub_drop     = '0;
`endif

endmodule
